// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the core and the multiply/divide unit.
// The core (master) issues start/op with the two register-file read buses;
// the unit (slave) returns busy/done and the architectural HI/LO registers.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the MIPS HI/LO registers.
// MULT/MULTU/DIV/DIVU run for ITERS iteration cycles plus one fix-up cycle,
// working on operand magnitudes; MTHI/MTLO write HI/LO directly from idle.
// ITERS is expected to equal WIDTH: one iteration consumes one operand bit.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input logic     clk,
  input logic     rst,
  mdu_hilo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_t state_q, state_d;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     magb;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 is_div;
  logic                 is_signed;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 idle_start;
  logic                 accept;
  logic                 do_mthi;
  logic                 do_mtlo;
  logic                 in_signed;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   acc_step;

  logic                 neg_res;
  logic                 neg_rem;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     fin_hi;
  logic [WIDTH-1:0]     fin_lo;

  // Request decode: op[2]=0 selects mul/div, op[1] selects divide, op[0] unsigned.
  // The unsigned WIDTH-bit magnitude of the most negative value is exactly
  // 2^(WIDTH-1), so it fits without overflow alongside the carry bit below.
  assign idle_start = (state_q == IDLE) && bus.start;
  assign accept     = idle_start && !bus.op[2];
  assign do_mthi    = idle_start && (bus.op == 3'd4);
  assign do_mtlo    = idle_start && (bus.op == 3'd5);
  assign in_signed  = !bus.op[0];
  assign mag_a      = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b      = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One iteration step. acc holds {partial, operand} for both operations:
  // multiply adds the multiplicand into the upper half and shifts right,
  // divide shifts left and keeps the trial subtraction if it did not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magb} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, magb};
    acc_step  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH]) begin
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Sign correction applied in the closing cycle; a zero divisor bypasses it
  // so the architectural result is always all-ones quotient and HI=dividend.
  always_comb begin
    neg_res  = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_rem  = is_signed && a_q[WIDTH-1];
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        fin_hi = a_q;
        fin_lo = '1;
      end else begin
        fin_hi = rem_fix;
        fin_lo = quo_fix;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: idle until a mul/div is accepted, iterate, then one fix-up cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (cnt == CW'(ITERS - 1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and HI/LO registers: latch operands on accept, step each RUN
  // cycle, commit the corrected result and pulse done at the FIN edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      magb      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            is_div    <= bus.op[1];
            is_signed <= in_signed;
            acc       <= {{WIDTH{1'b0}}, mag_a};
            magb      <= mag_b;
          end else if (do_mthi) begin
            hi_q <= bus.a;
          end else if (do_mtlo) begin
            lo_q <= bus.a;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          hi_q   <= fin_hi;
          lo_q   <= fin_lo;
          done_q <= 1'b1;
          cnt    <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
